muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO multiply/divide resource. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the execute stage, drives the registered multiplier, runs a 32-step restoring divider, and owns the architectural HI/LO registers. While an operation is in flight it stalls the pipeline on any HI/LO access.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_ctrl_div_iter.sv | 73 +++++++
 rtl/muldiv_ctrl.sv | 133 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   W        operand / register width
//   CNT_W    width of the divider step counter
//   op_t     3-bit HI/LO operation codes from the execute stage
//   state_t  sequencer states
//   negate_if  two's-complement negate, used for operand absolute values
//              and for the quotient/remainder sign fix
package muldiv_pkg;

  localparam int W     = 32;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL_WB,
    DIV_RUN,
    DIV_FIX
  } state_t;

  // Negate block: returns -v when en is set, v otherwise.
  function automatic logic [W-1:0] negate_if(input logic [W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter
// 32-step restoring divider datapath (unsigned magnitudes only).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               load dividend/divisor, clear remainder, count = W-1
//   step                perform one restoring step this cycle
//   dividend, divisor   unsigned operands sampled on start
//   quotient, remainder current quotient / remainder registers
//   done                high during the final step (count == 0)
module div_iter
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [W-1:0]     dividend,
  input  logic [W-1:0]     divisor,
  output logic [W-1:0]     quotient,
  output logic [W-1:0]     remainder,
  output logic             done
);

  // The quotient register starts out holding the dividend: each step
  // shifts its MSB into the partial remainder and a quotient bit into
  // its LSB, so after W steps it holds only quotient bits.
  logic [W-1:0]     quo_q;
  logic [W-1:0]     rem_q;
  logic [W-1:0]     dsr_q;
  logic [CNT_W-1:0] count_q;

  logic [W:0]   r_ext;
  logic [W:0]   r_sub;
  logic         fits;
  logic [W-1:0] rem_next;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    r_ext    = {rem_q, quo_q[W-1]};
    r_sub    = r_ext - {1'b0, dsr_q};
    fits     = (r_ext >= {1'b0, dsr_q});
    rem_next = r_ext[W-1:0];
    // The remainder stays below the divisor (or below 2^W for a zero
    // divisor), so the difference always fits in W bits.
    if (fits) rem_next = r_sub[W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      count_q <= '0;
    end else if (start) begin
      quo_q   <= dividend;
      rem_q   <= '0;
      dsr_q   <= divisor;
      count_q <= CNT_W'(W - 1);
    end else if (step) begin
      quo_q <= {quo_q[W-2:0], fits};
      rem_q <= rem_next;
      if (count_q != '0) count_q <= count_q - 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = step && (count_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Sequencer for the HI/LO multiply/divide resource. Accepts HI/LO ops from
// the execute stage, strobes an external registered multiplier, runs the
// restoring divider and owns the architectural HI/LO registers.
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   OP_VALID, OP, A, B  operation and operands from execute
//   KILL                flush: the presented op is discarded
//   STALL               presented op not accepted this cycle
//   BUSY                an operation is in flight
//   RESULT              MFHI/MFLO read data (LO when not reading HI)
//   MUL_EN, MUL_SIGN    multiplier capture strobe and signed select
//   MUL_A, MUL_B        multiplier operands (A, B pass-through)
//   MUL_HI, MUL_LO      registered product, valid the cycle after MUL_EN
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         OP_VALID,
  input  logic [2:0]   OP,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         KILL,
  output logic         STALL,
  output logic         BUSY,
  output logic [W-1:0] RESULT,
  output logic         MUL_EN,
  output logic         MUL_SIGN,
  output logic [W-1:0] MUL_A,
  output logic [W-1:0] MUL_B,
  input  logic [W-1:0] MUL_HI,
  input  logic [W-1:0] MUL_LO
);

  state_t       state;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
  logic         quot_neg_q;
  logic         rem_neg_q;

  op_t          op;
  logic         live;
  logic         idle;
  logic         accept;
  logic         is_mul;
  logic         is_div;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_done;

  assign op     = op_t'(OP);
  assign live   = OP_VALID && !KILL;
  assign idle   = (state == IDLE);
  assign accept = live && idle;
  assign STALL  = live && !idle;
  assign BUSY   = !idle;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);

  assign MUL_EN   = accept && is_mul;
  assign MUL_SIGN = accept && (op == OP_MULT);
  assign MUL_A    = A;
  assign MUL_B    = B;

  assign RESULT = (accept && (op == OP_MFHI)) ? hi_q : lo_q;

  // Signed divide works on magnitudes; signs are restored in DIV_FIX.
  assign a_neg = (op == OP_DIV) && A[W-1];
  assign b_neg = (op == OP_DIV) && B[W-1];
  assign abs_a = negate_if(A, a_neg);
  assign abs_b = negate_if(B, b_neg);

  div_iter u_div (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .start     (accept && is_div),
    .step      (state == DIV_RUN),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (div_done)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: state <= MUL_WB;
              OP_DIV, OP_DIVU: begin
                quot_neg_q <= a_neg ^ b_neg;
                rem_neg_q  <= a_neg;
                state      <= DIV_RUN;
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;  // MFHI/MFLO only read
            endcase
          end
        end
        MUL_WB: begin
          hi_q  <= MUL_HI;
          lo_q  <= MUL_LO;
          state <= IDLE;
        end
        DIV_RUN: begin
          if (div_done) state <= DIV_FIX;
        end
        DIV_FIX: begin
          lo_q  <= negate_if(quotient, quot_neg_q);
          hi_q  <= negate_if(remainder, rem_neg_q);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
// Directed scoreboard bench for muldiv_ctrl. Reads push their expected
// data into a queue; a monitor pops and compares whenever an MFHI/MFLO
// is accepted. The external registered multiplier is modelled here.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         OP_VALID;
  logic [2:0]   OP;
  logic [W-1:0] A, B;
  logic         KILL;
  logic         STALL, BUSY, MUL_EN, MUL_SIGN;
  logic [W-1:0] RESULT, MUL_A, MUL_B, MUL_HI, MUL_LO;
  logic [63:0]  mul_prod = '0;

  typedef struct {
    string        name;
    logic [W-1:0] val;
  } sb_t;

  sb_t sb[$];
  int  passed = 0;
  int  total  = 0;
  int  busy_cnt = 0;
  int  mul_pulses = 0;

  muldiv_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .OP_VALID(OP_VALID), .OP(OP), .A(A), .B(B),
    .KILL(KILL), .STALL(STALL), .BUSY(BUSY), .RESULT(RESULT), .MUL_EN(MUL_EN),
    .MUL_SIGN(MUL_SIGN), .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_HI(MUL_HI), .MUL_LO(MUL_LO)
  );

  always #5 CLK = ~CLK;

  // Registered multiplier: product available the cycle after MUL_EN.
  always @(posedge CLK) begin
    if (MUL_EN) begin
      if (MUL_SIGN) mul_prod <= $signed(MUL_A) * $signed(MUL_B);
      else          mul_prod <= {32'd0, MUL_A} * {32'd0, MUL_B};
    end
  end
  assign MUL_HI = mul_prod[63:32];
  assign MUL_LO = mul_prod[31:0];

  always @(negedge CLK) begin
    if (BUSY)   busy_cnt++;
    if (MUL_EN) mul_pulses++;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare RESULT whenever a read is accepted.
  always @(negedge CLK) begin
    if (RESET_N && OP_VALID && !KILL && !STALL &&
        (OP == OP_MFHI || OP == OP_MFLO)) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_read: got %h expected no read", RESULT);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check(e.name, RESULT, e.val);
      end
    end
  end

  // Present an op starting in the current cycle and hold it until accepted.
  // Returns the number of stall cycles and MUL_EN/MUL_SIGN in the accept cycle.
  task automatic present(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int stalls, output logic en, output logic sg);
    bit ok;
    OP_VALID = 1'b1; OP = op; A = a; B = b; KILL = 1'b0;
    stalls = 0; ok = 1'b0; en = 1'b0; sg = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!STALL) begin
        ok = 1'b1;
        en = MUL_EN;
        sg = MUL_SIGN;
        break;
      end
      stalls++;
      @(posedge CLK); #1;
    end
    if (!ok) begin
      total++;
      $display("FAIL stall_timeout: got %0d stalls expected acceptance", stalls);
    end
    @(posedge CLK); #1;
    OP_VALID = 1'b0;
  endtask

  task automatic read(input op_t op, input logic [W-1:0] exp, input string name,
                      input int exp_stalls);
    int st; logic en, sg;
    sb.push_back('{name: name, val: exp});
    present(op, '0, '0, st, en, sg);
    check({name, "_stalls"}, W'(st), W'(exp_stalls));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st; logic en, sg;
    RESET_N = 1'b0; OP_VALID = 1'b0; OP = '0; A = '0; B = '0; KILL = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;

    // Reset state
    @(negedge CLK);
    check("rst_busy",   W'(BUSY),   W'(0));
    check("rst_stall",  W'(STALL),  W'(0));
    check("rst_mul_en", W'(MUL_EN), W'(0));
    check("rst_result", RESULT,     32'h0);
    @(posedge CLK); #1;

    // MULTU 0xFFFFFFFF * 2, MFLO right behind it stalls once
    mul_pulses = 0;
    present(OP_MULTU, 32'hFFFFFFFF, 32'd2, st, en, sg);
    check("multu_en",   W'(en), W'(1));
    check("multu_sign", W'(sg), W'(0));
    read(OP_MFLO, 32'hFFFFFFFE, "multu_lo", 1);
    check("multu_en_pulses", W'(mul_pulses), W'(1));
    read(OP_MFHI, 32'h00000001, "multu_hi", 0);

    // MULT -3 * 5 = -15
    present(OP_MULT, 32'hFFFFFFFD, 32'd5, st, en, sg);
    check("mult_sign", W'(sg), W'(1));
    read(OP_MFHI, 32'hFFFFFFFF, "mult_hi", 1);
    read(OP_MFLO, 32'hFFFFFFF1, "mult_lo", 0);

    // DIV -7 / 2: q=-3, r=-1; MFLO at T+1 accepted at T+34
    busy_cnt = 0;
    present(OP_DIV, 32'hFFFFFFF9, 32'd2, st, en, sg);
    read(OP_MFLO, 32'hFFFFFFFD, "div_m7_lo", 33);
    check("div_busy_cycles", W'(busy_cnt), W'(33));
    read(OP_MFHI, 32'hFFFFFFFF, "div_m7_hi", 0);

    // DIVU by zero
    present(OP_DIVU, 32'h12345678, 32'h0, st, en, sg);
    read(OP_MFLO, 32'hFFFFFFFF, "divu_z_lo", 33);
    read(OP_MFHI, 32'h12345678, "divu_z_hi", 0);

    // DIV most-negative / -1
    present(OP_DIV, 32'h80000000, 32'hFFFFFFFF, st, en, sg);
    read(OP_MFLO, 32'h80000000, "div_ovf_lo", 33);
    read(OP_MFHI, 32'h00000000, "div_ovf_hi", 0);

    // MTHI during DIV_RUN: killed copy does not stall, live copy stalls to IDLE
    present(OP_DIVU, 32'd100, 32'd7, st, en, sg);
    OP_VALID = 1'b1; OP = OP_MTHI; A = 32'hCAFEF00D; KILL = 1'b1;
    @(negedge CLK);
    check("mthi_kill_busy_stall", W'(STALL), W'(0));
    @(posedge CLK); #1;
    present(OP_MTHI, 32'hCAFEF00D, '0, st, en, sg);
    check("mthi_stalls", W'(st), W'(32));
    read(OP_MFHI, 32'hCAFEF00D, "mthi_hi", 0);
    read(OP_MFLO, 32'h0000000E, "divu_100_7_lo", 0);

    // Killed MTHI in IDLE leaves HI untouched
    OP_VALID = 1'b1; OP = OP_MTHI; A = 32'h12345678; KILL = 1'b1;
    @(negedge CLK);
    check("mthi_kill_idle_stall", W'(STALL), W'(0));
    @(posedge CLK); #1;
    OP_VALID = 1'b0; KILL = 1'b0;
    read(OP_MFHI, 32'hCAFEF00D, "mthi_kill_hi", 0);

    // MTLO
    present(OP_MTLO, 32'h55AA55AA, '0, st, en, sg);
    read(OP_MFLO, 32'h55AA55AA, "mtlo_lo", 0);

    // Reset at the 10th DIV_RUN cycle aborts the divide
    present(OP_DIV, 32'hFFFFFFF9, 32'd2, st, en, sg);
    repeat (9) @(posedge CLK);
    #1;
    check("busy_before_reset", W'(BUSY), W'(1));
    RESET_N = 1'b0;
    #1;
    check("busy_in_reset", W'(BUSY), W'(0));
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    read(OP_MFHI, 32'h00000000, "post_rst_hi", 0);
    read(OP_MFLO, 32'h00000000, "post_rst_lo", 0);

    check("scoreboard_drained", W'(sb.size()), W'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
